// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: steers the free-running PC so it advances once per retired instruction.
// PC controls are Mealy (same-edge capture); optional interrupt entry/return tracking under PC_SEQUENCER_IRQ_EN.
module pc_sequencer #(
    parameter int          TIMEOUT      = 15,
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        HaltReq,
    input  logic [15:0] PcValue,
    output logic        FetchReq,
    input  logic        FetchAck,
    input  logic        ExecDone,
    input  logic        JumpTaken,
    input  logic [15:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [8:0]  BranchOffset,
    output logic        LoadEnable,
    output logic [15:0] LoadValue,
    output logic        OffsetEnable,
    output logic [8:0]  Offset,
    output logic        Running,
    output logic        Fault,
`ifdef PC_SEQUENCER_IRQ_EN
    input  logic        IrqReq,
    input  logic [15:0] IrqVector,
    output logic        IrqAck,
    output logic [15:0] ReturnAddr,
`endif
    output logic [15:0] InstrCount
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, FAULT} state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic        halt_pend;
    logic        retire;
    logic        halt_now;
    logic        timeout_hit;
    logic        irq_take;
    logic [15:0] irq_vec;

    assign retire      = (state == EXEC) && ExecDone;
    assign halt_now    = HaltReq || halt_pend;
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

`ifdef PC_SEQUENCER_IRQ_EN
    logic        irq_mask;
    logic [15:0] advance_addr;

    assign irq_take = retire && IrqReq && !halt_pend && !irq_mask;
    assign irq_vec  = IrqVector;

    always_comb begin
        advance_addr = PcValue + 16'd1;
        if (JumpTaken)
            advance_addr = JumpTarget;
        else if (BranchTaken)
            advance_addr = PcValue + {{7{BranchOffset[8]}}, BranchOffset};
    end

    // Mask stays set until software returns by jumping to the saved address.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            IrqAck     <= 1'b0;
            ReturnAddr <= 16'h0000;
            irq_mask   <= 1'b0;
        end else begin
            IrqAck <= irq_take;
            if (irq_take) begin
                ReturnAddr <= advance_addr;
                irq_mask   <= 1'b1;
            end else if (retire && JumpTaken && (JumpTarget == ReturnAddr)) begin
                irq_mask   <= 1'b0;
            end
        end
    end
`else
    assign irq_take = 1'b0;
    assign irq_vec  = 16'h0000;
`endif

    // Anything that is not an advance reloads PcValue, cancelling the PC's free-run increment.
    always_comb begin
        next_state   = state;
        LoadEnable   = 1'b1;
        LoadValue    = PcValue;
        OffsetEnable = 1'b0;
        Offset       = 9'h000;
        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    LoadValue  = RESET_VECTOR;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (FetchAck)
                    next_state = EXEC;
                else if (timeout_hit)
                    next_state = FAULT;
            end
            EXEC: begin
                if (ExecDone) begin
                    if (irq_take) begin
                        LoadValue = irq_vec;
                    end else if (JumpTaken) begin
                        LoadValue = JumpTarget;
                    end else if (BranchTaken) begin
                        LoadEnable   = 1'b0;
                        OffsetEnable = 1'b1;
                        Offset       = BranchOffset;
                    end else begin
                        LoadEnable = 1'b0;
                    end
                    next_state = halt_now ? HALT : FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            halt_pend  <= 1'b0;
            InstrCount <= 16'h0000;
            Fault      <= 1'b0;
            FetchReq   <= 1'b0;
            Running    <= 1'b0;
        end else begin
            state    <= next_state;
            FetchReq <= (next_state == FETCH);
            Running  <= (next_state == FETCH) || (next_state == EXEC);
            Fault    <= Fault || (next_state == FAULT);
            wait_cnt <= ((state == FETCH) && (next_state == FETCH)) ? wait_cnt + 8'd1 : 8'd0;
            if (retire)
                InstrCount <= InstrCount + 16'd1;
            // A halt request is held until the retire that consumes it; IDLE ignores it.
            if (retire)
                halt_pend <= 1'b0;
            else if (HaltReq && (state != IDLE))
                halt_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, fault/IRQ sequences, then random traffic against an architectural model.
module tb_pc_sequencer;

    localparam int          TO = 15;
    localparam logic [15:0] RV = 16'h0000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start, HaltReq, FetchAck, ExecDone, JumpTaken, BranchTaken;
    logic [15:0] JumpTarget;
    logic [8:0]  BranchOffset;
    logic [15:0] PcValue;
    logic        FetchReq, LoadEnable, OffsetEnable, Running, Fault;
    logic [15:0] LoadValue, InstrCount;
    logic [8:0]  Offset;
`ifdef PC_SEQUENCER_IRQ_EN
    logic        IrqReq, IrqAck;
    logic [15:0] IrqVector, ReturnAddr;
`endif

    int n_pass  = 0;
    int n_total = 0;

    pc_sequencer #(.TIMEOUT(TO), .RESET_VECTOR(RV)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .HaltReq(HaltReq),
        .PcValue(PcValue), .FetchReq(FetchReq), .FetchAck(FetchAck),
        .ExecDone(ExecDone), .JumpTaken(JumpTaken), .JumpTarget(JumpTarget),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .LoadEnable(LoadEnable), .LoadValue(LoadValue),
        .OffsetEnable(OffsetEnable), .Offset(Offset),
        .Running(Running), .Fault(Fault),
`ifdef PC_SEQUENCER_IRQ_EN
        .IrqReq(IrqReq), .IrqVector(IrqVector), .IrqAck(IrqAck), .ReturnAddr(ReturnAddr),
`endif
        .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    // The program counter itself: free-runs unless loaded or offset.
    logic [15:0] pc;
    always @(posedge Clock or posedge Reset) begin
        if (Reset)             pc <= 16'h0000;
        else if (LoadEnable)   pc <= LoadValue;
        else if (OffsetEnable) pc <= pc + {{7{Offset[8]}}, Offset};
        else                   pc <= pc + 16'd1;
    end
    assign PcValue = pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        st, ack, done, jmp;
        logic [15:0] tgt;
        logic        br;
        logic [8:0]  off;
        logic        hreq;
        logic        exp_oe;
        logic [15:0] exp_pc;
        logic [15:0] exp_cnt;
        logic        exp_run;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic ack, input logic done, input logic jmp,
                                input logic [15:0] tgt, input logic br, input logic [8:0] off,
                                input logic hreq, input logic oe, input logic [15:0] epc,
                                input logic [15:0] ecnt, input logic run);
        vec_t v;
        v.st = st; v.ack = ack; v.done = done; v.jmp = jmp; v.tgt = tgt; v.br = br;
        v.off = off; v.hreq = hreq; v.exp_oe = oe; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_run = run;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Start = v.st; FetchAck = v.ack; ExecDone = v.done; JumpTaken = v.jmp;
        JumpTarget = v.tgt; BranchTaken = v.br; BranchOffset = v.off; HaltReq = v.hreq;
    endtask

    task automatic idle_inputs();
        Start = 1'b0; FetchAck = 1'b0; ExecDone = 1'b0; JumpTaken = 1'b0;
        JumpTarget = 16'h0000; BranchTaken = 1'b0; BranchOffset = 9'h000; HaltReq = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        idle_inputs();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // One clock with the given inputs, leaving the bench just after the edge.
    task automatic step(input vec_t v);
        @(negedge Clock);
        drive(v);
        @(posedge Clock);
        #1;
    endtask

    vec_t tbl[21];

    // Architectural model state for the random phase.
    int          md;   // 0 idle, 1 fetching, 2 executing, 3 halted, 4 faulted
    int          wt;
    bit          hp;
    logic [15:0] mpc, mcnt;

    initial begin
        Reset = 1'b1;
        idle_inputs();
`ifdef PC_SEQUENCER_IRQ_EN
        IrqReq = 1'b0; IrqVector = 16'h0000;
`endif
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_running", Running, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_count", InstrCount, 0);
        chk("rst_fetchreq", FetchReq, 0);
        chk("rst_load_en", LoadEnable, 1);
        chk("rst_load_val", LoadValue, 16'h0000);
        chk("rst_offset_en", OffsetEnable, 0);
        @(negedge Clock);
        Reset = 1'b0;

        //             st    ack   done  jmp   tgt       br    off     hreq  oe    pc        cnt  run
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b1);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0001, 16'd1, 1'b1);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0001, 16'd1, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0010, 16'd2, 1'b1);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0010, 16'd2, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 9'h005, 1'b0, 1'b0, 16'h1234, 16'd3, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h1234, 16'd3, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0100, 16'd4, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0100, 16'd4, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 9'h005, 1'b0, 1'b1, 16'h0105, 16'd5, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b1, 1'b0, 16'h0105, 16'd5, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0105, 16'd5, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0105, 16'd5, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0106, 16'd6, 1'b0);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0106, 16'd6, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 9'h003, 1'b0, 1'b0, 16'h0106, 16'd6, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, RV,       16'd6, 1'b1);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, RV,       16'd6, 1'b1);
        tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, RV + 16'd1, 16'd7, 1'b1);

        for (int i = 0; i < 21; i++) begin
            @(negedge Clock);
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d_offset_en", i), OffsetEnable, tbl[i].exp_oe);
            @(posedge Clock);
            #1;
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_count", i), InstrCount, tbl[i].exp_cnt);
            chk($sformatf("vec%0d_running", i), Running, tbl[i].exp_run);
        end

        // Fetch timeout: sequencer is fetching at PC 0001; ack never comes.
        for (int k = 1; k <= TO; k++) begin
            @(negedge Clock);
            idle_inputs();
            @(posedge Clock);
            #1;
            chk($sformatf("timeout_fault_c%0d", k), Fault, (k == TO));
        end
        chk("timeout_pc_frozen", pc, RV + 16'd1);
        step(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("fault_start_ignored_pc", pc, RV + 16'd1);
        chk("fault_sticky", Fault, 1);
        chk("fault_not_running", Running, 0);
        @(negedge Clock);
        idle_inputs();
        Reset = 1'b1;
        #1;
        chk("reset_clears_fault", Fault, 0);
        chk("reset_clears_count", InstrCount, 0);
        @(negedge Clock);
        Reset = 1'b0;

`ifdef PC_SEQUENCER_IRQ_EN
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("irq_pre_pc", pc, 16'h0020);
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        IrqReq = 1'b1; IrqVector = 16'h0800;
        step(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("irq_pc_vector", pc, 16'h0800);
        chk("irq_return_addr", ReturnAddr, 16'h0021);
        chk("irq_ack_pulse", IrqAck, 1);
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("irq_ack_single", IrqAck, 0);
        step(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("irq_masked_pc", pc, 16'h0801);
        chk("irq_masked_ack", IrqAck, 0);
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0021, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("irq_return_pc", pc, 16'h0021);
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0));
        chk("irq_unmasked_pc", pc, 16'h0800);
        chk("irq_unmasked_ack", IrqAck, 1);
        chk("irq_unmasked_ret", ReturnAddr, 16'h0022);
        IrqReq = 1'b0;
        do_reset();
`endif

        // Random traffic against an architectural model of PC and counters.
        md = 0; wt = 0; hp = 1'b0; mpc = 16'h0000; mcnt = 16'h0000;
        for (int c = 0; c < 4000; c++) begin
            int  old;
            bit  nh;
            bit  rst;
            @(negedge Clock);
            rst = ($urandom % 200 == 0) || (md == 4 && $urandom % 10 == 0);
            if (rst) begin
                Reset = 1'b1;
                idle_inputs();
                md = 0; wt = 0; hp = 1'b0; mpc = 16'h0000; mcnt = 16'h0000;
            end else begin
                Reset        = 1'b0;
                Start        = ($urandom % 8 == 0);
                FetchAck     = ($urandom % 3 == 0);
                ExecDone     = ($urandom % 2 == 0);
                JumpTaken    = ($urandom % 4 == 0);
                JumpTarget   = 16'($urandom);
                BranchTaken  = ($urandom % 3 == 0);
                BranchOffset = 9'($urandom);
                HaltReq      = ($urandom % 16 == 0);
                old = md;
                nh  = hp;
                case (old)
                    0, 3: if (Start) begin mpc = RV; md = 1; wt = 0; end
                    1: begin
                        if (FetchAck) md = 2;
                        else begin
                            wt++;
                            if (wt == TO) md = 4;
                        end
                    end
                    2: if (ExecDone) begin
                        mcnt = mcnt + 16'd1;
                        if (JumpTaken)        mpc = JumpTarget;
                        else if (BranchTaken) mpc = mpc + {{7{BranchOffset[8]}}, BranchOffset};
                        else                  mpc = mpc + 16'd1;
                        md = (HaltReq || hp) ? 3 : 1;
                        wt = 0;
                        nh = 1'b0;
                    end
                    default: ;
                endcase
                if (old != 0 && HaltReq && !(old == 2 && ExecDone)) nh = 1'b1;
                hp = nh;
            end
            @(posedge Clock);
            #1;
            chk($sformatf("rnd%0d_pc", c), pc, mpc);
            chk($sformatf("rnd%0d_count", c), InstrCount, mcnt);
            chk($sformatf("rnd%0d_running", c), Running, (md == 1 || md == 2));
            chk($sformatf("rnd%0d_fault", c), Fault, (md == 4));
            chk($sformatf("rnd%0d_fetchreq", c), FetchReq, (md == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
